median_stream: RTL
==================

Name: median_stream

Overview:
- Streaming 3x3 median filter for raster-order pixel streams. It is the sequential, parametrised successor of the combinational 3x3 median.
- Two internal line buffers build the 3x3 window. A pipelined sorting network computes the median.
- Valid/ready handshakes on input and output. The block sits between the pixel source and downstream image stages.
- Emits only interior pixels ("valid" window mode): the output frame is (IMG_W-2) x (IMG_H-2).

Parameters:
- DATA_W, 8: pixel width in bits (unsigned).
- IMG_W, 8: pixels per line. Minimum 3.
- IMG_H, 6: lines per frame. Minimum 3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_pixel  in  DATA_W  input pixel.
- in_sof  in  1  marks the first pixel of a frame. Qualified by in_valid.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- out_pixel  out  DATA_W  median of the 3x3 window.
- out_sof  out  1  first output pixel of a frame.
- out_eol  out  1  last output pixel of an output row.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_sof=0, out_eol=0, out_pixel=0.
  - Row and column counters = 0. Pipeline valid bits = 0. Line buffer contents are don't-care.
  - in_ready=1 from the first cycle after reset.
- Stall rule: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - Input accepted when in_valid & in_ready.
  - Every pipeline stage advances only when ~stall. Bubbles (no accepted input) advance as invalid entries.
- Position tracking:
  - col/row count accepted beats. col wraps at IMG_W-1, which increments row. row wraps at IMG_H-1 to 0, so back-to-back frames need no in_sof.
  - An accepted beat with in_sof=1 is treated as position (0,0), whatever the counters hold. Counters then continue from (0,1).
- Window:
  - On each accept, the pixel is shifted into the 3-column window. Line buffer 1 is read and written at col; line buffer 0 feeds buffer 1.
  - When input (r,c) is accepted, the window holds rows r-2..r and columns c-2..c.
- Emit condition: the window is output-valid when r>=2 and c>=2 at acceptance. Its centre is (r-1,c-1).
- Frame restart: in_sof mid-frame aborts the current frame.
  - No further windows from the old frame are generated. Beats already in the pipeline still drain.
  - Windows mixing old- and new-frame lines must never be emitted; the r>=2 and c>=2 gate guarantees this.
- Median pipeline, 3 registered stages:
  - S1: sort each window row (min, med, max).
  - S2: max of the three mins; med3 of the three meds; min of the three maxes.
  - S3: med3 of the S2 results → out_pixel.
  - Comparisons are unsigned. Ties are legal and produce the correct median. No width growth.
- Latency: with no stall, out_valid rises 3 clock edges after the accepting edge of the completing input beat. Throughput is 1 pixel/clock.
- Output sideband:
  - out_sof=1 with centre (1,1).
  - out_eol=1 with centre column IMG_W-2.
  - Both are carried through the pipeline with the data.
- Held output: while stalled, out_pixel, out_sof and out_eol stay stable. No beat is lost or duplicated.
- Reset mid-frame: all pipeline contents and position are discarded immediately. The next accepted beat is (0,0).

Test Plan:
- Reset with rst_n=0 for 3 cycles, in_valid=0 → out_valid=0, out_sof=0, out_eol=0; in_ready=1 after release.
- Ramp frame, IMG_W=8, IMG_H=6, pixel=r*8+c, out_ready=1:
  - Exactly 24 outputs, equal to the centre values 9..14, 17..22, 25..30, 33..38.
  - out_sof only on 9. out_eol on 14, 22, 30, 38.
  - First out_valid 3 cycles after accepting pixel 18.
- Impulse: all-zero frame with 255 at (2,3) and 255 at (4,5) → all 24 outputs = 0. Repeat with all-255 frame and a 0 impulse → all outputs = 255.
- Backpressure: ramp frame with out_ready pattern 1,0,1,0… then held 0 for 10 cycles → in_ready=0 whenever out_valid&~out_ready; output sequence identical to the ramp case; no drops or duplicates.
- Mid-frame restart: in_sof asserted at row 3, col 4 of the ramp frame, then a full new frame.
  - Old in-flight beats drain.
  - No output until new pixel (2,2) is accepted. That output has out_sof=1 and value = new (1,1).
  - Total new-frame outputs = 24.
- Random: 20 frames of $random 8-bit pixels, including runs of equal values and 0/255 extremes, with random out_ready → outputs match a behavioural 9-element sort model.

Source files
------------

// File: rtl/median_stream.sv
// Streaming 3x3 median filter over raster-order pixels, emitting interior
// pixels only. Line buffers build the window; a 3-stage sorting network picks the median.
module median_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_pixel,
    input  logic              in_sof,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_pixel,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef logic [DATA_W-1:0] pix_t;

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a < b) ? b : a;
    endfunction

    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic          stall;
    logic          accept;
    logic          emit;
    logic [CW-1:0] col, col_pos;
    logic [RW-1:0] row, row_pos;

    pix_t lb0 [IMG_W];
    pix_t lb1 [IMG_W];
    pix_t win [3][3];   // [line][column]; line 0 is oldest, column 2 newest

    logic v0, sof0, eol0;
    pix_t s1_min [3];
    pix_t s1_med [3];
    pix_t s1_max [3];
    logic v1, sof1, eol1;
    pix_t s2_lo, s2_md, s2_hi;
    logic v2, sof2, eol2;

    always_comb begin
        stall    = out_valid & ~out_ready;
        in_ready = ~stall;
        accept   = in_valid & in_ready;
        // An in_sof beat restarts position at (0,0) regardless of the counters.
        col_pos  = in_sof ? '0 : col;
        row_pos  = in_sof ? '0 : row;
        emit     = (row_pos >= RW'(2)) && (col_pos >= CW'(2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_pos == COL_LAST) begin
                col <= '0;
                row <= (row_pos == ROW_LAST) ? '0 : row_pos + 1'b1;
            end else begin
                col <= col_pos + 1'b1;
                row <= row_pos;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col_pos] <= in_pixel;
            lb1[col_pos] <= lb0[col_pos];
            for (int unsigned r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1[col_pos];
            win[1][2] <= lb0[col_pos];
            win[2][2] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0        <= 1'b0;
            sof0      <= 1'b0;
            eol0      <= 1'b0;
            v1        <= 1'b0;
            sof1      <= 1'b0;
            eol1      <= 1'b0;
            v2        <= 1'b0;
            sof2      <= 1'b0;
            eol2      <= 1'b0;
            s2_lo     <= '0;
            s2_md     <= '0;
            s2_hi     <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_pixel <= '0;
            for (int unsigned r = 0; r < 3; r++) begin
                s1_min[r] <= '0;
                s1_med[r] <= '0;
                s1_max[r] <= '0;
            end
        end else if (!stall) begin
            v0   <= accept & emit;
            sof0 <= accept & emit & (row_pos == RW'(2)) & (col_pos == CW'(2));
            eol0 <= accept & emit & (col_pos == COL_LAST);

            for (int unsigned r = 0; r < 3; r++) begin
                s1_min[r] <= min2(min2(win[r][0], win[r][1]), win[r][2]);
                s1_med[r] <= med3(win[r][0], win[r][1], win[r][2]);
                s1_max[r] <= max2(max2(win[r][0], win[r][1]), win[r][2]);
            end
            v1   <= v0;
            sof1 <= sof0;
            eol1 <= eol0;

            s2_lo <= max2(max2(s1_min[0], s1_min[1]), s1_min[2]);
            s2_md <= med3(s1_med[0], s1_med[1], s1_med[2]);
            s2_hi <= min2(min2(s1_max[0], s1_max[1]), s1_max[2]);
            v2    <= v1;
            sof2  <= sof1;
            eol2  <= eol1;

            out_pixel <= med3(s2_lo, s2_md, s2_hi);
            out_valid <= v2;
            out_sof   <= sof2;
            out_eol   <= eol2;
        end
    end

endmodule
